// File: rtl/p_pkg.sv
// Shared definitions for the packed arithmetic units: pack-width bit indices,
// multiplier FSM states and the pack-width to lane-width decode.
package p_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PW_W   = 5;
  localparam int unsigned CNT_W  = 5;

  localparam int unsigned PW_32 = 0;
  localparam int unsigned PW_16 = 1;
  localparam int unsigned PW_8  = 2;
  localparam int unsigned PW_4  = 3;
  localparam int unsigned PW_2  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  // Lane width W from one-hot pw, lowest set bit wins; zero means 32.
  function automatic logic [5:0] lane_width(input logic [PW_W-1:0] pw);
    logic [5:0] w;
    if (pw[PW_32])      w = 6'd32;
    else if (pw[PW_16]) w = 6'd16;
    else if (pw[PW_8])  w = 6'd8;
    else if (pw[PW_4])  w = 6'd4;
    else if (pw[PW_2])  w = 6'd2;
    else                w = 6'd32;
    return w;
  endfunction

  // W-1: doubles as the in-lane bit-index mask and the final step count.
  function automatic logic [CNT_W-1:0] lane_mask(input logic [PW_W-1:0] pw);
    return CNT_W'(lane_width(pw) - 6'd1);
  endfunction

endpackage

// File: rtl/p_addsub.sv
// Packed add/subtract: independent carry chains per lane, lane width from pw.
module p_addsub
  import p_pkg::*;
(
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [PW_W-1:0] pw,
  input  logic            sub,
  output logic [XLEN-1:0] result
);

  logic [CNT_W-1:0] mask;
  logic             carry;
  logic             cin;
  logic             b;

  // Ripple chain; the carry is replaced by the lane carry-in at every lane LSB.
  always_comb begin
    mask   = lane_mask(pw);
    carry  = 1'b0;
    cin    = 1'b0;
    b      = 1'b0;
    result = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      cin       = ((CNT_W'(i) & mask) == '0) ? sub : carry;
      b         = rhs[i] ^ sub;
      result[i] = lhs[i] ^ b ^ cin;
      carry     = (lhs[i] & b) | (cin & (lhs[i] ^ b));
    end
  end

endmodule

// File: rtl/p_mul_seq.sv
// Sequential packed shift-add multiplier, one step per cycle per lane.
// Optional carry-less mode is built when P_MUL_CLMUL_EN is defined.
module p_mul_seq
  import p_pkg::*;
(
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            valid,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [PW_W-1:0] pw,
  input  logic            high,
  input  logic            clmul,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  lhs_q;
  logic [PW_W-1:0]  pw_q;
  logic             high_q;

  logic [CNT_W-1:0] mask;
  logic [XLEN-1:0]  add_b;
  logic [XLEN-1:0]  sum_add;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  sum_sr;
  logic [XLEN-1:0]  lo_sr;
  logic [XLEN-1:0]  nxt_hi;
  logic [XLEN-1:0]  nxt_lo;
  logic             carry_en;
  logic             lane_c;
  logic [CNT_W-1:0] lsb_idx;

`ifdef P_MUL_CLMUL_EN
  logic clmul_q;
`else
  logic unused_clmul;
  assign unused_clmul = clmul;
`endif

  // Addend is lhs where the lane's multiplier LSB is set, otherwise zero.
  always_comb begin
    mask  = lane_mask(pw_q);
    add_b = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      add_b[i] = lhs_q[i] & acc_lo[CNT_W'(i) & ~mask];
    end
  end

  p_addsub u_addsub (
    .lhs    (acc_hi),
    .rhs    (add_b),
    .pw     (pw_q),
    .sub    (1'b0),
    .result (sum_add)
  );

  always_comb begin
`ifdef P_MUL_CLMUL_EN
    sum      = clmul_q ? (acc_hi ^ add_b) : sum_add;
    carry_en = ~clmul_q;
`else
    sum      = sum_add;
    carry_en = 1'b1;
`endif
  end

  // Shift {carry, sum, acc_lo} right by one inside each lane.
  always_comb begin
    sum_sr  = {1'b0, sum[XLEN-1:1]};
    lo_sr   = {1'b0, acc_lo[XLEN-1:1]};
    nxt_hi  = '0;
    nxt_lo  = '0;
    lane_c  = 1'b0;
    lsb_idx = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      lsb_idx = CNT_W'(i) & ~mask;
      if ((CNT_W'(i) & mask) == mask) begin
        lane_c    = carry_en & ((acc_hi[i] & add_b[i]) |
                                ((acc_hi[i] | add_b[i]) & ~sum[i]));
        nxt_hi[i] = lane_c;
        nxt_lo[i] = sum[lsb_idx];
      end else begin
        nxt_hi[i] = sum_sr[i];
        nxt_lo[i] = lo_sr[i];
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      lhs_q   <= '0;
      pw_q    <= '0;
      high_q  <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
`ifdef P_MUL_CLMUL_EN
      clmul_q <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            acc_lo  <= rhs;
            acc_hi  <= '0;
            cnt     <= '0;
            lhs_q   <= lhs;
            pw_q    <= pw;
            high_q  <= high;
            result  <= high ? '0 : rhs;
`ifdef P_MUL_CLMUL_EN
            clmul_q <= clmul;
`endif
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Dropping valid abandons the op; the partial product stays put.
          if (!valid) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            result <= high_q ? nxt_hi : nxt_lo;
            if (cnt == mask) begin
              state <= S_DONE;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_mul_seq.sv
// Self-checking bench for p_mul_seq against an arithmetic per-lane product model.
module tb_p_mul_seq;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        valid;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  pw;
  logic        high;
  logic        clmul;
  logic        ready;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 g_clk = ~g_clk;

  p_mul_seq dut (
    .g_clk  (g_clk),
    .g_rst  (g_rst),
    .valid  (valid),
    .lhs    (lhs),
    .rhs    (rhs),
    .pw     (pw),
    .high   (high),
    .clmul  (clmul),
    .ready  (ready),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lane_w(input logic [4:0] p);
    if (p[0]) return 32;
    if (p[1]) return 16;
    if (p[2]) return 8;
    if (p[3]) return 4;
    if (p[4]) return 2;
    return 32;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a_in, input logic [31:0] b_in,
                                          input logic [4:0] p, input logic h, input logic c);
    int w;
    longint unsigned m, a, b, pr, r, x, y;
    bit clm;
    w = lane_w(p);
    m = (64'd1 << w) - 64'd1;
    x = 64'(a_in);
    y = 64'(b_in);
    r = 0;
`ifdef P_MUL_CLMUL_EN
    clm = c;
`else
    clm = 1'b0;
    if (c) clm = 1'b0;
`endif
    for (int l = 0; l < 32 / w; l++) begin
      a = (x >> (l * w)) & m;
      b = (y >> (l * w)) & m;
      if (clm) begin
        pr = 0;
        for (int j = 0; j < w; j++)
          if (((b >> j) & 64'd1) != 0) pr = pr ^ (a << j);
      end else begin
        pr = a * b;
      end
      r = r | ((((h ? (pr >> w) : pr)) & m) << (l * w));
    end
    return 32'(r);
  endfunction

  // Drives one request and checks latency, result and the single-cycle ready.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                        input logic h, input logic c, input bit scramble, input string tag);
    int cyc;
    logic [31:0] exp;
    exp   = ref_mul(a, b, p, h, c);
    lhs   = a;
    rhs   = b;
    pw    = p;
    high  = h;
    clmul = c;
    valid = 1'b1;
    cyc   = 0;
    do begin
      @(posedge g_clk);
      #1;
      cyc++;
      if (scramble && cyc == 1) begin
        lhs   = $urandom;
        rhs   = $urandom;
        pw    = 5'($urandom);
        high  = ~h;
        clmul = ~c;
      end
    end while (!ready && cyc < 40);
    check({tag, "_lat"}, 32'(cyc), 32'(lane_w(p) + 1));
    check({tag, "_res"}, result, exp);
    valid = 1'b0;
    @(posedge g_clk);
    #1;
    check({tag, "_pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    g_rst = 1'b1;
    valid = 1'b0;
    lhs   = '0;
    rhs   = '0;
    pw    = '0;
    high  = 1'b0;
    clmul = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_result", result, 32'h0);
    g_rst = 1'b0;
    @(posedge g_clk);
    #1;

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, 1'b0, 1'b0, "w32_lo");
    check("w32_lo_const", result, 32'h00000001);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b1, 1'b0, 1'b0, "w32_hi");
    check("w32_hi_const", result, 32'hFFFFFFFE);
    run_op(32'h0003FFFF, 32'h0005FFFF, 5'b00010, 1'b0, 1'b0, 1'b0, "w16_lo");
    check("w16_lo_const", result, 32'h000F0001);
    run_op(32'h0003FFFF, 32'h0005FFFF, 5'b00010, 1'b1, 1'b0, 1'b0, "w16_hi");
    check("w16_hi_const", result, 32'h0000FFFE);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b0, 1'b0, 1'b0, "w2_lo");
    check("w2_lo_const", result, 32'h55555555);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b1, 1'b0, 1'b0, "w2_hi");
    check("w2_hi_const", result, 32'hAAAAAAAA);
    run_op(32'h03030303, 32'h03030303, 5'b00100, 1'b0, 1'b0, 1'b0, "w8_int");
    check("w8_int_const", result, 32'h09090909);
    run_op(32'h03030303, 32'h03030303, 5'b00100, 1'b0, 1'b1, 1'b0, "w8_clm");
`ifdef P_MUL_CLMUL_EN
    check("w8_clm_const", result, 32'h05050505);
`else
    check("w8_clm_const", result, 32'h09090909);
`endif
    run_op(32'h12345678, 32'h9ABCDEF1, 5'b00000, 1'b1, 1'b0, 1'b0, "pw_zero");
    run_op(32'hDEADBEEF, 32'hCAFEF00D, 5'b00110, 1'b0, 1'b0, 1'b0, "pw_multi");
    run_op(32'hA5A5C3C3, 32'h5A5A3C3C, 5'b00100, 1'b1, 1'b0, 1'b1, "scramble");

    // Abort: drop valid in BUSY cycle 5 of a W=32 op.
    lhs   = 32'hFFFFFFFF;
    rhs   = 32'hFFFFFFFF;
    pw    = 5'b00001;
    high  = 1'b0;
    valid = 1'b1;
    repeat (5) begin
      @(posedge g_clk);
      #1;
    end
    valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge g_clk);
      #1;
      if (ready) check("abort_no_ready", 32'(ready), 32'd0);
    end
    check("abort_idle_ready", 32'(ready), 32'd0);
    run_op(32'h77777777, 32'h77777777, 5'b01000, 1'b0, 1'b0, 1'b0, "post_abort");
    check("post_abort_const", result, 32'h11111111);

    // Reset in the middle of an op.
    lhs   = 32'h00000003;
    rhs   = 32'h0000F00D;
    pw    = 5'b00001;
    high  = 1'b0;
    valid = 1'b1;
    repeat (10) begin
      @(posedge g_clk);
      #1;
    end
    g_rst = 1'b1;
    @(posedge g_clk);
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_result", result, 32'h0);
    g_rst = 1'b0;
    valid = 1'b0;
    @(posedge g_clk);
    #1;

    for (int n = 0; n < 30; n++) begin
      run_op($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
